muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M multiply/divide, one bit per cycle in CALC.
// Define MULDIV_EARLY_OUT_EN to let trivial operations skip CALC.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic accept, sa_in, sb_in, under;
  logic [XLEN:0] sum, sh;
  logic [XLEN-1:0] sub, hi_s, lo_s, quo, rem, fin;
  logic [2*XLEN-1:0] prod;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign result = result_q;
  assign accept = in_valid && in_ready;
  // hi:lo holds the running product (multiply) or remainder:quotient (divide)
  always_comb begin
    sa_in = ((op[2] && !op[0]) || (!op[2] && (op[1] ^ op[0]))) && rs1[XLEN-1];
    sb_in = ((op[2] && !op[0]) || op == 3'b001) && rs2[XLEN-1];
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh = {hi_q, lo_q[XLEN-1]};
    under = sh < {1'b0, b_q};
    sub = sh[XLEN-1:0] - b_q;
    hi_s = op_q[2] ? (under ? sh[XLEN-1:0] : sub) : sum[XLEN:1];
    lo_s = op_q[2] ? {lo_q[XLEN-2:0], !under} : {sum[0], lo_q[XLEN-1:1]};
    prod = (sa_q ^ sb_q) ? -{hi_s, lo_s} : {hi_s, lo_s};
    quo = b_q == '0 ? '1 : ((sa_q ^ sb_q) ? -lo_s : lo_s);
    rem = sa_q ? -hi_s : hi_s;
    fin = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
`ifdef MULDIV_EARLY_OUT_EN
  logic div0, ovf, mul0;
  logic [XLEN-1:0] early_res;
  always_comb begin
    div0 = op[2] && rs2 == '0;
    ovf = op[2] && !op[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
    mul0 = !op[2] && (rs1 == '0 || rs2 == '0);
    early_res = div0 ? (op[1] ? rs1 : '1) : (ovf ? (op[1] ? '0 : rs1) : '0);
  end
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    hi_d = hi_q;
    lo_d = lo_q;
    b_d = b_q;
    result_d = result_q;
    if (accept) begin
      op_d = op;
      sa_d = sa_in;
      sb_d = sb_in;
      hi_d = '0;
      lo_d = sa_in ? -rs1 : rs1;
      b_d = sb_in ? -rs2 : rs2;
      cnt_d = '0;
      state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
      if (div0 || ovf || mul0) begin
        state_d = DONE;
        result_d = early_res;
      end
`endif
    end else if (state_q == CALC) begin
      hi_d = hi_s;
      lo_d = lo_s;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN-1)) begin
        state_d = DONE;
        result_d = fin;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q <= b_d;
      result_q <= result_d;
    end
  end
endmodule
